button_press_classifier: RTL and testbench



---
 rtl/button_press_classifier.sv | 160 ++++++++++++++++
 tb/tb_button_press_classifier.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/button_press_classifier.sv
// Classifies a debounced button level into short press, long press and double click pulses.
// Define HOLD_REPEAT_EN to add auto-repeat pulses while a long press is held.
module button_press_classifier #(
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int DOUBLE_GAP_CYCLES = 300,
  parameter int REPEAT_CYCLES     = 200,
  parameter int CNT_WIDTH         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_press,
  output logic busy
);

  if (LONG_PRESS_CYCLES < 2 || DOUBLE_GAP_CYCLES < 2 || REPEAT_CYCLES < 1 ||
      CNT_WIDTH < 1 || CNT_WIDTH > 31 ||
      (LONG_PRESS_CYCLES - 1) >= (2 ** CNT_WIDTH) ||
      (DOUBLE_GAP_CYCLES - 1) >= (2 ** CNT_WIDTH) ||
      (REPEAT_CYCLES - 1) >= (2 ** CNT_WIDTH)) begin : g_bad_param
    $error("button_press_classifier: illegal parameter combination");
  end

  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(DOUBLE_GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 btn_dly_q, btn_dly_d;
  logic                 short_q, short_d;
  logic                 long_q, long_d;
  logic                 double_q, double_d;
  logic                 rep_d;
  logic                 busy_q, busy_d;
  logic                 rise, fall;

  assign rise = btn_level & ~btn_dly_q;
  assign fall = ~btn_level & btn_dly_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    btn_dly_d = btn_level;
    short_d   = 1'b0;
    long_d    = 1'b0;
    double_d  = 1'b0;
    rep_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        // Release wins over the long-press threshold on the same edge.
        if (fall) begin
          state_d = WAIT_SECOND;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`ifdef HOLD_REPEAT_EN
        else if (cnt_q == CNT_WIDTH'(REPEAT_CYCLES - 1)) begin
          rep_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
      WAIT_SECOND: begin
        // A second press on the timeout edge still forms a double click.
        if (rise) begin
          state_d = SECOND_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      SECOND_PRESSED: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      btn_dly_q <= 1'b1;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      double_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_dly_q <= btn_dly_d;
      short_q   <= short_d;
      long_q    <= long_d;
      double_q  <= double_d;
      busy_q    <= busy_d;
    end
  end

`ifdef HOLD_REPEAT_EN
  logic rep_q;
  always_ff @(posedge clk) begin
    if (rst) rep_q <= 1'b0;
    else     rep_q <= rep_d;
  end
  assign repeat_press = rep_q;
`else
  logic unused_rep;
  assign unused_rep   = rep_d;
  assign repeat_press = 1'b0;
`endif

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = double_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier (L=8, gap=4, repeat=3); repeat checks follow HOLD_REPEAT_EN.
module tb_button_press_classifier;

  logic clk = 1'b0;
  logic rst;
  logic btn_level;
  logic short_press, long_press, double_click, repeat_press, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_short, n_long, n_dbl, n_rep, n_busy;
  int at_short, at_long, at_dbl, rep_first, rep_last, busy_clr_at;
  logic busy_prev = 1'b0;
  int s;

  button_press_classifier #(
    .LONG_PRESS_CYCLES(8),
    .DOUBLE_GAP_CYCLES(4),
    .REPEAT_CYCLES(3),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_level(btn_level),
    .short_press(short_press),
    .long_press(long_press),
    .double_click(double_click),
    .repeat_press(repeat_press),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic clr();
    n_short = 0; n_long = 0; n_dbl = 0; n_rep = 0; n_busy = 0;
    at_short = -1; at_long = -1; at_dbl = -1;
    rep_first = -1; rep_last = -1; busy_clr_at = -1;
  endtask

  // One negedge: sample registered outputs produced by the preceding posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (short_press)  begin n_short++; at_short = cyc; $display("event short_press cyc=%0d", cyc); end
    if (long_press)   begin n_long++;  at_long  = cyc; $display("event long_press cyc=%0d", cyc); end
    if (double_click) begin n_dbl++;   at_dbl   = cyc; $display("event double_click cyc=%0d", cyc); end
    if (repeat_press) begin
      n_rep++;
      if (rep_first < 0) rep_first = cyc;
      rep_last = cyc;
      $display("event repeat_press cyc=%0d", cyc);
    end
    if (busy) n_busy++;
    if (busy_prev && !busy) busy_clr_at = cyc;
    busy_prev = busy;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive high for h sampled edges, then low; start is the cycle before the first high edge.
  task automatic press(input int h, output int start);
    btn_level = 1'b1;
    start = cyc;
    run(h);
    btn_level = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    btn_level = 1'b0;
    clr();
    run(3);
    check("rst_short", short_press, 0);
    check("rst_long", long_press, 0);
    check("rst_double", double_click, 0);
    check("rst_repeat", repeat_press, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    run(3);

    // Short press: rise s+1, fall s+4, short at s+8
    clr();
    press(3, s);
    run(12);
    check("s1_n_short", n_short, 1);
    check("s1_at_short", at_short, s + 8);
    check("s1_n_long", n_long, 0);
    check("s1_n_dbl", n_dbl, 0);
    check("s1_busy_clr", busy_clr_at, s + 8);

    // Long press held 20: long at s+9, release at s+21 suppresses repeat at that edge
    clr();
    press(20, s);
    run(10);
    check("s2_n_long", n_long, 1);
    check("s2_at_long", at_long, s + 9);
    check("s2_n_short", n_short, 0);
    check("s2_n_dbl", n_dbl, 0);
    check("s2_busy_clr", busy_clr_at, s + 21);
`ifdef HOLD_REPEAT_EN
    check("s2_n_rep", n_rep, 3);
    check("s2_rep_first", rep_first, s + 12);
    check("s2_rep_last", rep_last, s + 18);
`else
    check("s2_n_rep", n_rep, 0);
`endif

    // Release exactly at the long threshold edge: fall wins, short at s+13
    clr();
    press(8, s);
    run(12);
    check("s3_n_long", n_long, 0);
    check("s3_n_short", n_short, 1);
    check("s3_at_short", at_short, s + 13);

    // Double click: high2 low2 high2 low -> double at s+7
    clr();
    btn_level = 1'b1; s = cyc;
    run(2); btn_level = 1'b0;
    run(2); btn_level = 1'b1;
    run(2); btn_level = 1'b0;
    run(10);
    check("s4_n_dbl", n_dbl, 1);
    check("s4_at_dbl", at_dbl, s + 7);
    check("s4_n_short", n_short, 0);

    // Second rise on the cnt==3 edge: high2 low4 high2 low -> double at s+9
    clr();
    btn_level = 1'b1; s = cyc;
    run(2); btn_level = 1'b0;
    run(4); btn_level = 1'b1;
    run(2); btn_level = 1'b0;
    run(10);
    check("s5_n_dbl", n_dbl, 1);
    check("s5_at_dbl", at_dbl, s + 9);
    check("s5_n_short", n_short, 0);

    // Long second press still yields double on release (fall at s+19), never long
    clr();
    btn_level = 1'b1; s = cyc;
    run(2); btn_level = 1'b0;
    run(1); btn_level = 1'b1;
    run(15); btn_level = 1'b0;
    run(10);
    check("s6_n_dbl", n_dbl, 1);
    check("s6_at_dbl", at_dbl, s + 19);
    check("s6_n_long", n_long, 0);
    check("s6_n_short", n_short, 0);

    // Button held through reset is not a press
    clr();
    btn_level = 1'b1; rst = 1'b1;
    run(2); rst = 1'b0;
    run(3); btn_level = 1'b0;
    run(8);
    check("s7_n_pulses", n_short + n_long + n_dbl + n_rep, 0);
    check("s7_n_busy", n_busy, 0);
    clr();
    press(3, s);
    run(12);
    check("s7_n_short", n_short, 1);
    check("s7_at_short", at_short, s + 8);

    // Reset during the release gap abandons the gesture
    clr();
    press(2, s);
    run(1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(10);
    check("s8_n_pulses", n_short + n_long + n_dbl, 0);
    check("s8_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
